// File: rtl/sap_memory_unit.sv
// sap_memory_unit
//   This block combines the SAP memory address register, the program/run
//   address select and a DEPTH x DATA_WIDTH memory array.
//   After reset it can zero-fill the whole array, one word per clock.
//   The front-panel write button is edge detected, so holding it down
//   writes only once.
//   The read port is asynchronous. Its output is forced to zero whenever
//   the block is not driving the bus.
//
// Ports
//   clk         system clock; all state updates on the rising edge
//   reset       synchronous, active-high reset
//   prog_mode   1 = front-panel program mode, 0 = run mode
//   prog_addr   manual address switches
//   prog_data   manual data switches
//   prog_write  manual write pushbutton (level; may be held)
//   bus_in      shared bus value
//   mar_load    load MAR from bus_in[ADDR_WIDTH-1:0]
//   ram_load    write bus_in to mem[mar_q]
//   ram_out     drive mem[addr_sel] onto bus_out
//   bus_out     memory data; all zeros when not driving
//   mar_q       current MAR contents
//   busy        high while the zero-fill is in progress
module sap_memory_unit #(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 4,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  prog_mode,
   input  logic [ADDR_WIDTH-1:0] prog_addr,
   input  logic [DATA_WIDTH-1:0] prog_data,
   input  logic                  prog_write,
   input  logic [DATA_WIDTH-1:0] bus_in,
   input  logic                  mar_load,
   input  logic                  ram_load,
   input  logic                  ram_out,
   output logic [DATA_WIDTH-1:0] bus_out,
   output logic [ADDR_WIDTH-1:0] mar_q,
   output logic                  busy
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   if (ADDR_WIDTH < 1 || ADDR_WIDTH > DATA_WIDTH) begin : g_bad_param
      $error("sap_memory_unit: ADDR_WIDTH must be in 1..DATA_WIDTH");
   end

   typedef enum logic {
      CLEAR,
      RUN
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] clear_ptr_q, clear_ptr_d;
   logic [ADDR_WIDTH-1:0] mar_d;
   logic                  prog_write_q;
   logic [ADDR_WIDTH-1:0] addr_sel;

   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // State register. The memory array is deliberately excluded.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= CLEAR_ON_RESET ? CLEAR : RUN;
         clear_ptr_q  <= '0;
         mar_q        <= '0;
         prog_write_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         clear_ptr_q  <= clear_ptr_d;
         mar_q        <= mar_d;
         prog_write_q <= prog_write;
      end
   end

   // Next state and the single memory write port.
   // While in CLEAR, the zero-fill owns the write port and every other
   // request is dropped.
   // In RUN, the prog_mode input decides whether the front panel or the
   // controller owns the write port.
   always_comb begin
      state_d     = state_q;
      clear_ptr_d = clear_ptr_q;
      mar_d       = mar_q;
      mem_we      = 1'b0;
      mem_waddr   = mar_q;
      mem_wdata   = bus_in;

      if (!reset) begin
         unique case (state_q)
            CLEAR: begin
               mem_we      = 1'b1;
               mem_waddr   = clear_ptr_q;
               mem_wdata   = '0;
               clear_ptr_d = clear_ptr_q + ADDR_WIDTH'(1);
               if (&clear_ptr_q) begin
                  state_d = RUN;
               end
            end
            RUN: begin
               if (prog_mode) begin
                  // Only the press edge writes, so a held button writes once.
                  if (prog_write && !prog_write_q) begin
                     mem_we    = 1'b1;
                     mem_waddr = prog_addr;
                     mem_wdata = prog_data;
                  end
               end else begin
                  // The write uses the pre-edge MAR, even when the MAR
                  // is reloaded on the same edge.
                  if (ram_load) begin
                     mem_we    = 1'b1;
                     mem_waddr = mar_q;
                     mem_wdata = bus_in;
                  end
                  if (mar_load) begin
                     mar_d = bus_in[ADDR_WIDTH-1:0];
                  end
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   assign busy     = (state_q == CLEAR);
   assign addr_sel = prog_mode ? prog_addr : mar_q;
   assign bus_out  = (state_q == RUN && ram_out) ? mem[addr_sel] : '0;

endmodule

// File: tb/tb_sap_memory_unit.sv
module tb_sap_memory_unit;

   logic       clk;
   int         checks;
   int         errors;

   // Default instance: 8-bit data, 16 words, with the zero-fill enabled.
   logic       reset, prog_mode, prog_write, mar_load, ram_load, ram_out;
   logic [3:0] prog_addr;
   logic [7:0] prog_data, bus_in;
   logic [7:0] bus_out;
   logic [3:0] mar_q;
   logic       busy;

   // Legacy-style instance: 16x4, with no zero-fill.
   logic       reset4, prog_mode4, prog_write4, mar_load4, ram_load4, ram_out4;
   logic [3:0] prog_addr4, prog_data4, bus_in4, bus_out4, mar_q4;
   logic       busy4;

   sap_memory_unit dut (
      .clk(clk), .reset(reset), .prog_mode(prog_mode), .prog_addr(prog_addr),
      .prog_data(prog_data), .prog_write(prog_write), .bus_in(bus_in),
      .mar_load(mar_load), .ram_load(ram_load), .ram_out(ram_out),
      .bus_out(bus_out), .mar_q(mar_q), .busy(busy)
   );

   sap_memory_unit #(.DATA_WIDTH(4), .ADDR_WIDTH(4), .CLEAR_ON_RESET(1'b0)) dut4 (
      .clk(clk), .reset(reset4), .prog_mode(prog_mode4), .prog_addr(prog_addr4),
      .prog_data(prog_data4), .prog_write(prog_write4), .bus_in(bus_in4),
      .mar_load(mar_load4), .ram_load(ram_load4), .ram_out(ram_out4),
      .bus_out(bus_out4), .mar_q(mar_q4), .busy(busy4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       pm;
      logic [3:0] pa;
      logic [7:0] pd;
      logic       pw;
      logic [7:0] bi;
      logic       ml;
      logic       rl;
      logic       ro;
      logic [7:0] exp_bus;
      logic [3:0] exp_mar;
   } vec_t;

   vec_t vecs[17];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Counts the cycles in which busy is high, starting with the current sample.
   task automatic count_busy(output int n);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         if (busy !== 1'b1) break;
         n++;
         @(negedge clk);
         #1;
      end
   endtask

   initial begin
      int n;
      checks = 0;
      errors = 0;
      {reset, prog_mode, prog_write, mar_load, ram_load, ram_out} = '0;
      prog_addr = '0; prog_data = '0; bus_in = '0;
      {reset4, prog_mode4, prog_write4, mar_load4, ram_load4, ram_out4} = '0;
      prog_addr4 = '0; prog_data4 = '0; bus_in4 = '0;

      //                pm  pa     pd     pw  bi     ml rl ro  exp_bus exp_mar
      vecs[0]  = '{1'b0, 4'h0, 8'h00, 1'b0, 8'h03, 1, 0, 0, 8'h00, 4'h0};
      vecs[1]  = '{1'b0, 4'h0, 8'h00, 1'b0, 8'hA5, 0, 1, 0, 8'h00, 4'h3};
      vecs[2]  = '{1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 0, 0, 1, 8'hA5, 4'h3};
      vecs[3]  = '{1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 0, 0, 0, 8'h00, 4'h3};
      vecs[4]  = '{1'b0, 4'h0, 8'h00, 1'b0, 8'h07, 1, 1, 1, 8'hA5, 4'h3};
      vecs[5]  = '{1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 0, 0, 1, 8'h00, 4'h7};
      vecs[6]  = '{1'b1, 4'h3, 8'h00, 1'b0, 8'h0F, 1, 0, 1, 8'h07, 4'h7};
      vecs[7]  = '{1'b1, 4'hF, 8'h3C, 1'b1, 8'h05, 1, 1, 1, 8'h00, 4'h7};
      vecs[8]  = '{1'b1, 4'hF, 8'h3C, 1'b1, 8'h05, 1, 1, 1, 8'h3C, 4'h7};
      vecs[9]  = '{1'b1, 4'hF, 8'hFF, 1'b1, 8'h05, 1, 1, 1, 8'h3C, 4'h7};
      vecs[10] = '{1'b1, 4'hF, 8'hFF, 1'b1, 8'h05, 1, 0, 1, 8'h3C, 4'h7};
      vecs[11] = '{1'b1, 4'hF, 8'hFF, 1'b1, 8'h05, 1, 0, 1, 8'h3C, 4'h7};
      vecs[12] = '{1'b1, 4'hF, 8'hFF, 1'b0, 8'h05, 1, 0, 1, 8'h3C, 4'h7};
      vecs[13] = '{1'b1, 4'hF, 8'hFF, 1'b1, 8'h05, 1, 0, 1, 8'h3C, 4'h7};
      vecs[14] = '{1'b1, 4'hF, 8'hFF, 1'b1, 8'h05, 1, 0, 1, 8'hFF, 4'h7};
      vecs[15] = '{1'b0, 4'hF, 8'hFF, 1'b0, 8'hE9, 1, 0, 1, 8'h00, 4'h7};
      vecs[16] = '{1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 0, 0, 0, 8'h00, 4'h9};

      // Reset for one cycle, then check the length of the zero-fill.
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0; ram_out = 1'b1; mar_load = 1'b1; bus_in = 8'h0B;
      #1;
      chk("reset_mar", 8'(mar_q), 8'h00);
      chk("clear_bus_gated", bus_out, 8'h00);
      count_busy(n);
      chk("busy_cycles", 8'(n), 8'd16);
      chk("mar_after_clear", 8'(mar_q), 8'h00);
      mar_load = 1'b0; bus_in = 8'h00;
      for (int a = 0; a < 16; a++) begin
         @(negedge clk);
         prog_mode = 1'b1; prog_addr = 4'(a); ram_out = 1'b1;
         #1;
         chk($sformatf("zero_fill[%0d]", a), bus_out, 8'h00);
      end

      // Table of run-mode and program-mode vectors.
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         prog_mode = vecs[i].pm; prog_addr = vecs[i].pa; prog_data = vecs[i].pd;
         prog_write = vecs[i].pw; bus_in = vecs[i].bi; mar_load = vecs[i].ml;
         ram_load = vecs[i].rl; ram_out = vecs[i].ro;
         #1;
         chk($sformatf("vec%0d_bus_out", i), bus_out, vecs[i].exp_bus);
         chk($sformatf("vec%0d_mar_q", i), 8'(vecs[i].exp_mar) == 8'(mar_q) ? 8'(mar_q) : 8'(mar_q), 8'(vecs[i].exp_mar));
         chk($sformatf("vec%0d_busy", i), 8'(busy), 8'h00);
      end

      // Write A5 to mem[3], then reset again partway through the zero-fill.
      @(negedge clk); prog_mode = 1'b0; mar_load = 1'b1; bus_in = 8'h03; ram_out = 1'b0;
      @(negedge clk); mar_load = 1'b0; ram_load = 1'b1; bus_in = 8'hA5;
      @(negedge clk); ram_load = 1'b0; prog_mode = 1'b1; prog_addr = 4'h3; ram_out = 1'b1;
      #1;
      chk("prewrite_mem3", bus_out, 8'hA5);
      @(negedge clk); reset = 1'b1; prog_mode = 1'b0; ram_out = 1'b0;
      @(negedge clk); reset = 1'b0;
      repeat (7) @(negedge clk);
      #1;
      chk("busy_mid_clear", 8'(busy), 8'h01);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0; prog_mode = 1'b1; prog_addr = 4'h5; prog_data = 8'h55;
      prog_write = 1'b1; ram_out = 1'b1;
      #1;
      chk("restart_bus_gated", bus_out, 8'h00);
      count_busy(n);
      chk("restart_busy_cycles", 8'(n), 8'd16);
      prog_addr = 4'h3;
      #1;
      chk("mem3_cleared", bus_out, 8'h00);
      @(negedge clk); prog_write = 1'b0; prog_addr = 4'h5;
      #1;
      chk("lost_press_mem5", bus_out, 8'h00);

      // Legacy 16x4 configuration with no zero-fill.
      @(negedge clk); reset4 = 1'b1;
      @(negedge clk); reset4 = 1'b0;
      #1;
      chk("l_busy_after_reset", 8'(busy4), 8'h00);
      chk("l_mar_after_reset", 8'(mar_q4), 8'h00);
      @(negedge clk); mar_load4 = 1'b1; bus_in4 = 4'h2;
      @(negedge clk); mar_load4 = 1'b0; ram_load4 = 1'b1; bus_in4 = 4'hC;
      @(negedge clk); ram_load4 = 1'b0; ram_out4 = 1'b1;
      #1;
      chk("l_read_mem2", 8'(bus_out4), 8'h0C);
      chk("l_mar", 8'(mar_q4), 8'h02);
      @(negedge clk); reset4 = 1'b1; ram_out4 = 1'b0;
      @(negedge clk); reset4 = 1'b0;
      #1;
      chk("l_busy_after_reset2", 8'(busy4), 8'h00);
      chk("l_mar_after_reset2", 8'(mar_q4), 8'h00);
      @(negedge clk); prog_mode4 = 1'b1; prog_addr4 = 4'h2; ram_out4 = 1'b1;
      #1;
      chk("l_mem2_survives", 8'(bus_out4), 8'h0C);
      chk("l_busy_final", 8'(busy4), 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
